pll_lock_supervisor: RTL and testbench

Controls the reset/lock interface of the video clock PLL (50 MHz in; 42.954540 MHz and 10.738635 MHz out) from the free-running `refclk` side. It pulses the PLL reset and waits for lock. Lock must stay stable before the downstream system reset is released. On lock loss it re-asserts system reset and restarts the PLL. Sits between board reset and the PLL instance and gates reset into the Y/C pattern generator.

---
 rtl/pll_lock_supervisor.sv | 169 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_supervisor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : pll_lock_supervisor
// Brief  : Pulses the PLL reset, qualifies lock stability and gates the
//          downstream system reset. Optional retry limit: PLL_SUP_RETRY_LIMIT_EN.
// Rev    : 1.0 - initial release
// ============================================================================
module pll_lock_supervisor #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 500000,
    parameter int LOCK_STABLE_CYCLES  = 65536,
    parameter int MAX_RETRIES         = 8
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [7:0] retry_count,
    output logic       fault
);

    localparam int c_max_ab     = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ?
                                  PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int c_max_cycles = (c_max_ab > LOCK_STABLE_CYCLES) ?
                                  c_max_ab : LOCK_STABLE_CYCLES;
    localparam int c_cnt_w      = $clog2(c_max_cycles) + 1;

    localparam logic [c_cnt_w-1:0] c_rst_last    = c_cnt_w'(PLL_RST_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_to_last     = c_cnt_w'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_stable_last = c_cnt_w'(LOCK_STABLE_CYCLES - 1);
    localparam logic [7:0]         c_fault_at    = 8'(MAX_RETRIES);

`ifdef PLL_SUP_RETRY_LIMIT_EN
    localparam bit c_limit_en = 1'b1;
`else
    localparam bit c_limit_en = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABILIZE = 3'd2,
        S_RUN       = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    state_t             w_fail_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [7:0]         r_retry;
    logic [7:0]         w_retry_nxt;
    logic [7:0]         w_retry_inc;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_pll_rst;
    logic               r_sys_rst;
    logic               r_ready;

    // pll_locked is asynchronous to refclk; r_sync2 is the only consumer view
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= pll_locked;
            r_sync2 <= r_sync1;
        end
    end

    assign w_retry_inc  = (r_retry == 8'hFF) ? 8'hFF : r_retry + 8'd1;
    assign w_fail_state = (c_limit_en && (w_retry_inc == c_fault_at)) ? S_FAULT : S_RESET_PLL;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + c_cnt_w'(1);
        w_retry_nxt = r_retry;
        case (r_state)
            S_RESET_PLL: begin
                if (r_cnt == c_rst_last) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end
            end
            S_WAIT_LOCK: begin
                // Lock is checked first so it wins over a coincident timeout
                if (r_sync2) begin
                    w_state_nxt = S_STABILIZE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_to_last) begin
                    w_retry_nxt = w_retry_inc;
                    w_state_nxt = w_fail_state;
                    w_cnt_nxt   = '0;
                end
            end
            S_STABILIZE: begin
                if (!r_sync2) begin
                    w_state_nxt = S_WAIT_LOCK;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == c_stable_last) begin
                    w_state_nxt = S_RUN;
                    w_retry_nxt = 8'd0;
                    w_cnt_nxt   = '0;
                end
            end
            S_RUN: begin
                w_cnt_nxt = '0;
                if (!r_sync2) begin
                    w_retry_nxt = w_retry_inc;
                    w_state_nxt = w_fail_state;
                end
            end
            S_FAULT: begin
                w_cnt_nxt = '0;
            end
            default: begin
                w_state_nxt = S_RESET_PLL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Outputs are registered from the next state so they track r_state exactly
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state   <= S_RESET_PLL;
            r_cnt     <= '0;
            r_retry   <= 8'd0;
            r_pll_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_retry   <= w_retry_nxt;
            r_pll_rst <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAULT);
            r_sys_rst <= (w_state_nxt != S_RUN);
            r_ready   <= (w_state_nxt == S_RUN);
        end
    end

`ifdef PLL_SUP_RETRY_LIMIT_EN
    logic r_fault;

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_fault <= 1'b0;
        end else begin
            r_fault <= (w_state_nxt == S_FAULT);
        end
    end

    assign fault = r_fault;
`else
    assign fault = 1'b0;
`endif

    assign pll_rst     = r_pll_rst;
    assign sys_rst     = r_sys_rst;
    assign ready       = r_ready;
    assign retry_count = r_retry;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module : tb_pll_lock_supervisor
// Brief  : Directed and random lock-input stimulus against a duration-based
//          reference model of the PLL lock supervisor.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_pll_lock_supervisor;

    localparam int P_RST  = 4;
    localparam int P_TO   = 100;
    localparam int P_STAB = 32;
    localparam int P_MAX  = 3;

`ifdef PLL_SUP_RETRY_LIMIT_EN
    localparam bit c_limit_en = 1'b1;
`else
    localparam bit c_limit_en = 1'b0;
`endif

    localparam int M_PULSE = 0;
    localparam int M_WAIT  = 1;
    localparam int M_STAB  = 2;
    localparam int M_RUN   = 3;
    localparam int M_FAULT = 4;

    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [7:0] retry_count;
    logic       fault;

    int n_checks = 0;
    int n_pass = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .LOCK_STABLE_CYCLES  (P_STAB),
        .MAX_RETRIES         (P_MAX)
    ) dut (
        .refclk      (refclk),
        .rst         (rst),
        .pll_locked  (pll_locked),
        .pll_rst     (pll_rst),
        .sys_rst     (sys_rst),
        .ready       (ready),
        .retry_count (retry_count),
        .fault       (fault)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: phase plus time spent in it, lock seen two edges late
    int m_ph = M_PULSE;
    int m_since = 0;
    int m_fails = 0;
    bit m_ls;
    bit m_hist[$] = '{1'b0, 1'b0};

    task automatic m_enter(input int ph);
        m_ph = ph;
        m_since = 0;
    endtask

    task automatic m_fail();
        m_fails = (m_fails < 255) ? m_fails + 1 : 255;
        if (c_limit_en && m_fails == P_MAX) m_enter(M_FAULT);
        else m_enter(M_PULSE);
    endtask

    always @(posedge refclk or posedge rst) begin
        if (rst) begin
            m_ph = M_PULSE;
            m_since = 0;
            m_fails = 0;
            m_hist = '{1'b0, 1'b0};
        end else begin
            m_ls = m_hist.pop_front();
            m_hist.push_back(pll_locked);
            m_since++;
            case (m_ph)
                M_PULSE: if (m_since == P_RST) m_enter(M_WAIT);
                M_WAIT: begin
                    if (m_ls) m_enter(M_STAB);
                    else if (m_since == P_TO) m_fail();
                end
                M_STAB: begin
                    if (!m_ls) m_enter(M_WAIT);
                    else if (m_since == P_STAB) begin
                        m_fails = 0;
                        m_enter(M_RUN);
                    end
                end
                M_RUN: if (!m_ls) m_fail();
                default: ;
            endcase
        end
    end

    function automatic logic [11:0] out_vec();
        return {pll_rst, sys_rst, ready, fault, retry_count};
    endfunction

    function automatic logic [11:0] model_vec();
        return {(m_ph == M_PULSE) || (m_ph == M_FAULT), m_ph != M_RUN, m_ph == M_RUN,
                c_limit_en && (m_ph == M_FAULT), 8'(m_fails)};
    endfunction

    always @(negedge refclk) check("scoreboard", 32'(out_vec()), 32'(model_vec()));

    function automatic logic sig(input int sel);
        case (sel)
            0:       return pll_rst;
            1:       return sys_rst;
            2:       return ready;
            default: return fault;
        endcase
    endfunction

    // Edges until the selected output reads val; -1 when the budget runs out
    task automatic wait_for(input int sel, input logic val, input int limit, output int k);
        k = 0;
        while (k < limit) begin
            @(negedge refclk);
            k++;
            if (sig(sel) === val) return;
        end
        k = -1;
    endtask

    task automatic pulse_rst();
        @(posedge refclk);
        #2 rst = 1'b1;
        @(negedge refclk);
        rst = 1'b0;
    endtask

    initial begin
        int k;
        int len;

        repeat (3) @(negedge refclk);
        check("reset_values", 32'(out_vec()), 32'h0C00);

        // Clean start
        rst = 1'b0;
        wait_for(0, 1'b0, 50, k);
        check("clean_pll_rst_len", k, 4);
        repeat (16) @(negedge refclk);
        pll_locked = 1'b1;
        wait_for(1, 1'b0, 200, k);
        check("clean_release_lat", k, 35);
        check("clean_ready", 32'(ready), 1);
        check("clean_retry", 32'(retry_count), 0);

        // Loss in RUN and recovery
        pll_locked = 1'b0;
        wait_for(1, 1'b1, 20, k);
        check("loss_sys_rst_lat", k, 3);
        check("loss_pll_rst", 32'(pll_rst), 1);
        check("loss_ready", 32'(ready), 0);
        check("loss_retry", 32'(retry_count), 1);
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        wait_for(2, 1'b1, 200, k);
        check("recover_lat", k, 35);
        check("recover_retry", 32'(retry_count), 0);

        // Unstable lock: a one-cycle dropout during STABILIZE is not a failure
        pll_locked = 1'b0;
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (20) @(negedge refclk);
        pll_locked = 1'b0;
        @(negedge refclk);
        pll_locked = 1'b1;
        repeat (30) @(negedge refclk);
        check("unstable_no_retry", 32'(retry_count), 1);
        check("unstable_held", 32'(sys_rst), 1);
        wait_for(1, 1'b0, 200, k);
        check("unstable_release_lat", (k < 0) ? k : k + 30, 35);

        // Lock timeout
        pll_locked = 1'b0;
        pulse_rst();
        for (int n = 1; n <= 2; n++) begin
            wait_for(0, 1'b0, 50, k);
            check("timeout_pulse_len", k, 4);
            wait_for(0, 1'b1, 200, k);
            check("timeout_period", k, 100);
            check("timeout_retry", 32'(retry_count), 32'(n));
            check("timeout_sys_rst", 32'(sys_rst), 1);
        end

`ifdef PLL_SUP_RETRY_LIMIT_EN
        wait_for(3, 1'b1, 300, k);
        check("fault_lat", k, 104);
        repeat (300) @(negedge refclk);
        check("fault_latched", 32'({pll_rst, sys_rst, ready, fault}), 32'b1101);
        check("fault_retry", 32'(retry_count), 3);
`else
        repeat (260 * 104) @(negedge refclk);
        check("retry_saturate", 32'(retry_count), 255);
        check("no_fault", 32'(fault), 0);
`endif

        // Reset mid-STABILIZE
        pulse_rst();
        repeat (10) @(negedge refclk);
        pll_locked = 1'b1;
        repeat (15) @(negedge refclk);
        check("stab_pre_reset", 32'({pll_rst, sys_rst, ready}), 32'b010);
        @(posedge refclk);
        #2 rst = 1'b1;
        #1 check("async_reset", 32'(out_vec()), 32'h0C00);
        @(negedge refclk);
        rst = 1'b0;
        wait_for(0, 1'b0, 50, k);
        check("restart_pulse", k, 4);

        // Random lock behaviour with occasional resets
        for (int seg = 0; seg < 80; seg++) begin
            if ($urandom_range(0, 19) == 0) pulse_rst();
            if ($urandom_range(0, 3) == 0) len = $urandom_range(40, 140);
            else len = $urandom_range(1, 40);
            pll_locked = ~pll_locked;
            repeat (len) @(negedge refclk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
